// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the forwarding unit.
//   hz_state_t : hazard FSM state encoding (RUN / LDSTALL / MEMWAIT)
//   REG_AW_DEF : default register-address width of the MIPS core
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
//   master : pipeline registers / memory side (drives hazard sources, consumes controls)
//   slave  : hazard controller (consumes hazard sources, drives controls)
// Hazard sources : if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
//                  ex_mem_branch_taken, mem_busy
// Controls       : pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_flush,
//                  pipe_hold, mem_timeout
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) ();

    logic [REG_AW-1:0] if_id_rs;
    logic [REG_AW-1:0] if_id_rt;
    logic              if_id_uses_rt;
    logic              id_ex_mem_read;
    logic [REG_AW-1:0] id_ex_rt;
    logic              ex_mem_branch_taken;
    logic              mem_busy;

    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic              ex_flush;
    logic              pipe_hold;
    logic              mem_timeout;

    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
               ex_mem_branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_flush,
               pipe_hold, mem_timeout
    );

    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
               ex_mem_branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_flush,
               pipe_hold, mem_timeout
    );

endinterface

// File: rtl/hazard_lu_cmp.sv
// Load-use RAW comparator: flags an IF/ID instruction that reads the register a load in
// ID/EX is about to write. Purely combinational.
//   if_id_rs, if_id_rt : source registers of the instruction in IF/ID
//   if_id_uses_rt      : IF/ID instruction actually reads rt
//   id_ex_mem_read     : ID/EX instruction is a load
//   id_ex_rt           : load destination register
//   hit                : stall required
module hazard_lu_cmp
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] id_ex_rt,
    output logic              hit
);

    // $zero is never a real dependency, so a load into r0 never stalls.
    assign hit = id_ex_mem_read && (id_ex_rt != '0) &&
                 ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use stalls, taken-branch
// squash, and pipe freeze while data memory is busy. Outputs are Mealy (zero latency).
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   hz (slave)     : hazard sources in, pipeline enables/flushes/hold out, sticky mem_timeout
//   perf_clr, perf_stall_cycles, perf_flush_events : only when HAZARD_PERF_CNT_EN is defined
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall / flush event counters).
//
// state   | meaning
// RUN     | normal issue; evaluates busy > branch > load-use each cycle
// LDSTALL | extra load-use bubbles still owed (LOAD_STALL_CYCLES > 1 only)
// MEMWAIT | data memory busy; pipe frozen. When busy drops, behaves exactly as RUN
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW            = REG_AW_DEF,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_PERF_CNT_EN
    input  logic        perf_clr,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events,
`endif
    hazard_ctrl_if.slave hz
);

    localparam int STALL_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
    localparam int BUSY_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_INIT = STALL_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [BUSY_W-1:0]  BUSY_MAX   = BUSY_W'(MEM_TIMEOUT);

    hz_state_t          state, state_nx;
    logic [STALL_W-1:0] stall_cnt, stall_nx;
    logic [BUSY_W-1:0]  busy_cnt;
    logic [BUSY_W:0]    busy_inc;
    logic               timeout_r;
    logic               lu_hit;

    logic pc_write_c, if_id_write_c, bubble_c, if_id_flush_c, ex_flush_c, hold_c;

    hazard_lu_cmp #(.REG_AW(REG_AW)) u_lu_cmp (
        .if_id_rs       (hz.if_id_rs),
        .if_id_rt       (hz.if_id_rt),
        .if_id_uses_rt  (hz.if_id_uses_rt),
        .id_ex_mem_read (hz.id_ex_mem_read),
        .id_ex_rt       (hz.id_ex_rt),
        .hit            (lu_hit)
    );

    always_comb begin
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        bubble_c      = 1'b0;
        if_id_flush_c = 1'b0;
        ex_flush_c    = 1'b0;
        hold_c        = 1'b0;
        state_nx      = RUN;
        stall_nx      = stall_cnt;

        if (rst) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            bubble_c      = 1'b1;
        end else if (hz.mem_busy) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            hold_c        = 1'b1;
            state_nx      = MEMWAIT;
        end else if (hz.ex_mem_branch_taken) begin
            // Branch stays frozen in EX/MEM during MEMWAIT, so this fires once on release.
            bubble_c      = 1'b1;
            if_id_flush_c = 1'b1;
            ex_flush_c    = 1'b1;
        end else if (state == LDSTALL) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            bubble_c      = 1'b1;
            stall_nx      = stall_cnt - STALL_W'(1);
            state_nx      = (stall_cnt == STALL_W'(1)) ? RUN : LDSTALL;
        end else if (lu_hit) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            bubble_c      = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nx = LDSTALL;
                stall_nx = STALL_INIT;
            end
        end
    end

    assign busy_inc = {1'b0, busy_cnt} + (BUSY_W + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            busy_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_nx;
            stall_cnt <= stall_nx;
            if (hz.mem_busy) begin
                if (busy_cnt != BUSY_MAX) begin
                    busy_cnt <= busy_cnt + BUSY_W'(1);
                end
                if ((MEM_TIMEOUT != 0) && (busy_inc >= {1'b0, BUSY_MAX})) begin
                    timeout_r <= 1'b1;
                end
            end else begin
                busy_cnt <= '0;
            end
        end
    end

    assign hz.pc_write     = pc_write_c;
    assign hz.if_id_write  = if_id_write_c;
    assign hz.id_ex_bubble = bubble_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.ex_flush     = ex_flush_c;
    assign hz.pipe_hold    = hold_c;
    assign hz.mem_timeout  = timeout_r;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else if (perf_clr) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (!pc_write_c && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (if_id_flush_c && (perf_flush_events != 32'hFFFF_FFFF)) begin
                perf_flush_events <= perf_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share one stimulus stream:
//   u_a : LOAD_STALL_CYCLES=1, MEM_TIMEOUT=8
//   u_b : LOAD_STALL_CYCLES=3, MEM_TIMEOUT=0 (timeout disabled)
// A behavioural model (owed-bubble count, consecutive-busy run length, event tallies) is
// compared against both instances every negedge; directed literal checks pin the model.
// Perf counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs, rt, idrt;
    logic       uses_rt, mr, br, busy, perf_clr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hz_a ();
    hazard_ctrl_if #(.REG_AW(5)) hz_b ();

    assign hz_a.if_id_rs = rs;            assign hz_b.if_id_rs = rs;
    assign hz_a.if_id_rt = rt;            assign hz_b.if_id_rt = rt;
    assign hz_a.if_id_uses_rt = uses_rt;  assign hz_b.if_id_uses_rt = uses_rt;
    assign hz_a.id_ex_mem_read = mr;      assign hz_b.id_ex_mem_read = mr;
    assign hz_a.id_ex_rt = idrt;          assign hz_b.id_ex_rt = idrt;
    assign hz_a.ex_mem_branch_taken = br; assign hz_b.ex_mem_branch_taken = br;
    assign hz_a.mem_busy = busy;          assign hz_b.mem_busy = busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ps_a, pf_a, ps_b, pf_b;
`endif

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(8)) u_a (
        .clk (clk),
        .rst (rst),
`ifdef HAZARD_PERF_CNT_EN
        .perf_clr          (perf_clr),
        .perf_stall_cycles (ps_a),
        .perf_flush_events (pf_a),
`endif
        .hz  (hz_a)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(0)) u_b (
        .clk (clk),
        .rst (rst),
`ifdef HAZARD_PERF_CNT_EN
        .perf_clr          (perf_clr),
        .perf_stall_cycles (ps_b),
        .perf_flush_events (pf_b),
`endif
        .hz  (hz_b)
    );

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_flush, pipe_hold}
    logic [5:0] act_a, act_b;
    assign act_a = {hz_a.pc_write, hz_a.if_id_write, hz_a.id_ex_bubble,
                    hz_a.if_id_flush, hz_a.ex_flush, hz_a.pipe_hold};
    assign act_b = {hz_b.pc_write, hz_b.if_id_write, hz_b.id_ex_bubble,
                    hz_b.if_id_flush, hz_b.ex_flush, hz_b.pipe_hold};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // ---------------- behavioural model ----------------
    localparam logic [5:0] O_RESET = 6'b001000;
    localparam logic [5:0] O_HOLD  = 6'b000001;
    localparam logic [5:0] O_FLUSH = 6'b111110;
    localparam logic [5:0] O_STALL = 6'b001000;
    localparam logic [5:0] O_RUN   = 6'b110000;

    int          m_lsc[2] = '{1, 3};
    int          m_mt[2]  = '{8, 0};
    int          m_owed[2];      // stall bubbles still owed after the current cycle
    int          m_run[2];       // consecutive busy cycles so far
    bit          m_to[2];
    longint      m_pst[2];
    longint      m_pfl[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_owed[k] = 0; m_run[k] = 0; m_to[k] = 0; m_pst[k] = 0; m_pfl[k] = 0;
        end
    end

    always @(negedge clk) begin
        bit         hit;
        logic [5:0] exp;
        logic [5:0] act;
        hit = mr && (idrt != 0) && ((idrt == rs) || (uses_rt && (idrt == rt)));
        for (int k = 0; k < 2; k++) begin
            act = (k == 0) ? act_a : act_b;
            if (rst)              exp = O_RESET;
            else if (busy)        exp = O_HOLD;
            else if (br)          exp = O_FLUSH;
            else if (m_owed[k] > 0 || hit) exp = O_STALL;
            else                  exp = O_RUN;
            chk((k == 0) ? "model_outs_a" : "model_outs_b", 32'(act), 32'(exp));
            chk_b((k == 0) ? "model_timeout_a" : "model_timeout_b",
                  (k == 0) ? hz_a.mem_timeout : hz_b.mem_timeout, rst ? 1'b0 : m_to[k]);
`ifdef HAZARD_PERF_CNT_EN
            chk((k == 0) ? "model_perf_stall_a" : "model_perf_stall_b",
                (k == 0) ? ps_a : ps_b, rst ? 32'd0 : 32'(m_pst[k]));
            chk((k == 0) ? "model_perf_flush_a" : "model_perf_flush_b",
                (k == 0) ? pf_a : pf_b, rst ? 32'd0 : 32'(m_pfl[k]));
`endif
            if (rst) begin
                m_owed[k] = 0; m_run[k] = 0; m_to[k] = 0; m_pst[k] = 0; m_pfl[k] = 0;
            end else begin
                if (busy || br)         m_owed[k] = 0;
                else if (m_owed[k] > 0) m_owed[k] = m_owed[k] - 1;
                else if (hit)           m_owed[k] = m_lsc[k] - 1;
                if (busy) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_mt[k] != 0 && m_run[k] >= m_mt[k]) m_to[k] = 1;
                end else begin
                    m_run[k] = 0;
                end
                if (perf_clr) begin
                    m_pst[k] = 0; m_pfl[k] = 0;
                end else begin
                    if (!exp[5] && m_pst[k] < 64'hFFFF_FFFF) m_pst[k] = m_pst[k] + 1;
                    if (exp[2]  && m_pfl[k] < 64'hFFFF_FFFF) m_pfl[k] = m_pfl[k] + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rs = '0; rt = '0; idrt = '0; uses_rt = 0; mr = 0; br = 0; busy = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; perf_clr = 1'b0; idle();
        @(negedge clk);
        chk_b("rst_pc_write", hz_a.pc_write, 1'b0);
        chk_b("rst_if_id_write", hz_a.if_id_write, 1'b0);
        chk_b("rst_bubble", hz_a.id_ex_bubble, 1'b1);
        chk_b("rst_hold", hz_a.pipe_hold, 1'b0);
        chk_b("rst_timeout", hz_a.mem_timeout, 1'b0);
        cycle(); rst = 1'b0;
        cycle();

        // single load-use stall on r8
        mr = 1; idrt = 5'd8; rs = 5'd8;
        @(negedge clk);
        chk_b("t1_pc_write", hz_a.pc_write, 1'b0);
        chk_b("t1_if_id_write", hz_a.if_id_write, 1'b0);
        chk_b("t1_bubble", hz_a.id_ex_bubble, 1'b1);
        cycle(); idle();
        @(negedge clk);
        chk("t1_after", 32'(act_a), 32'(O_RUN));
        repeat (3) cycle();

        // r0 never stalls; rt only counts when read
        mr = 1; idrt = 5'd0; rs = 5'd0;
        @(negedge clk);
        chk_b("t2_zero_reg", hz_a.pc_write, 1'b1);
        cycle(); idrt = 5'd5; rt = 5'd5; rs = 5'd1; uses_rt = 0;
        @(negedge clk);
        chk_b("t2_rt_unused", hz_a.pc_write, 1'b1);
        cycle(); uses_rt = 1;
        @(negedge clk);
        chk_b("t2_rt_used", hz_a.pc_write, 1'b0);
        cycle(); idle();
        repeat (3) cycle();

        // 3-cycle stall aborted by branch in its 2nd cycle
        mr = 1; idrt = 5'd4; rs = 5'd4;
        @(negedge clk);
        chk_b("t3_stall1", hz_b.pc_write, 1'b0);
        cycle(); idle(); br = 1;
        @(negedge clk);
        chk("t3_flush", 32'(act_b), 32'(O_FLUSH));
        cycle(); idle();
        @(negedge clk);
        chk("t3_run", 32'(act_b), 32'(O_RUN));
        cycle();

        // busy 4 cycles with branch pending -> flush once on release
        busy = 1; br = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_hold", 32'(act_a), 32'(O_HOLD));
            cycle();
        end
        busy = 0;
        @(negedge clk);
        chk("t4_flush", 32'(act_a), 32'(O_FLUSH));
        cycle(); idle();
        @(negedge clk);
        chk_b("t4_flush_once", hz_a.if_id_flush, 1'b0);
        cycle();

        // timeout after 8th busy cycle (A); never on B
        busy = 1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 8) chk_b("t5_not_yet", hz_a.mem_timeout, 1'b0);
            if (i == 9) chk_b("t5_set", hz_a.mem_timeout, 1'b1);
            cycle();
        end
        busy = 0;
        @(negedge clk);
        chk_b("t5_sticky", hz_a.mem_timeout, 1'b1);
        chk_b("t5_disabled", hz_b.mem_timeout, 1'b0);
        cycle();

        // reset asserted while B is in its extra stall cycles
        mr = 1; idrt = 5'd4; rs = 5'd4;
        cycle(); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_mid_stall", 32'(act_b), 32'(O_RESET));
        chk_b("t6_rst_timeout", hz_a.mem_timeout, 1'b0);
        cycle(); rst = 1'b0; idle();
        @(negedge clk);
        chk("t6_no_pending", 32'(act_b), 32'(O_RUN));
        cycle();

`ifdef HAZARD_PERF_CNT_EN
        mr = 1; idrt = 5'd7; rs = 5'd7; cycle(); idle(); cycle();
        mr = 1; idrt = 5'd7; rs = 5'd7; cycle(); idle(); cycle();
        br = 1; cycle(); idle();
        @(negedge clk);
        chk("t7_perf_stall", ps_a, 32'd2);
        chk("t7_perf_flush", pf_a, 32'd1);
        perf_clr = 1; cycle(); perf_clr = 0;
        @(negedge clk);
        chk("t7_clr_stall", ps_a, 32'd0);
        chk("t7_clr_flush", pf_a, 32'd0);
        cycle();
`endif

        // randomized traffic
        repeat (3000) begin
            rs      = 5'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 3));
            idrt    = 5'($urandom_range(0, 3));
            uses_rt = 1'($urandom_range(0, 1));
            mr      = 1'($urandom_range(0, 1));
            br      = ($urandom_range(0, 9) == 0);
            busy    = busy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            perf_clr = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0; perf_clr = 0; idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
